// File: rtl/fp_mul_seq_pkg.sv
// rtl/fp_mul_seq_pkg.sv - shared types and constants for the sequential fp multiplier
// Purpose: FSM state enum, IEEE-754 single-precision field widths and special
//          values, and an operand classifier shared by the top and round/pack.
// Ports:   none (package)
package fp_mul_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int MANT_W = FRAC_W + 1;   // hidden bit included
   localparam int PROD_W = 2 * MANT_W;
   localparam int EXPS_W = 10;           // signed working exponent

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam int          BIAS    = 127;
   localparam int          EXP_INF = 255;

   // Returns {nan, inf, zero}; a denormal (exp==0) counts as zero.
   function automatic logic [2:0] fp_class(input logic [31:0] x);
      logic [EXP_W-1:0]  e;
      logic [FRAC_W-1:0] f;
      e = x[30:23];
      f = x[22:0];
      fp_class = {(e == EXP_W'(EXP_INF)) && (f != '0),
                  (e == EXP_W'(EXP_INF)) && (f == '0),
                  (e == '0)};
   endfunction

endpackage

// File: rtl/fp_mul_seq_round_pack.sv
// rtl/fp_mul_seq_round_pack.sv - normalise, round and pack a raw product
// Purpose: combinational normalisation (1-bit), round-to-nearest-even,
//          overflow/underflow clamping and special-case selection.
// Ports:   sign_i, exp_i (10-bit signed biased sum), prod_i (48-bit raw
//          mantissa product), nan_i/inf_i/zero_i special flags, res_o result.
module fp_round_pack
   import fp_mul_seq_pkg::*;
(
   input  logic                     sign_i,
   input  logic signed [EXPS_W-1:0] exp_i,
   input  logic [PROD_W-1:0]        prod_i,
   input  logic                     nan_i,
   input  logic                     inf_i,
   input  logic                     zero_i,
   output logic [31:0]              res_o
);

   logic [MANT_W-1:0]        mant;
   logic [MANT_W:0]          mant_r;
   logic                     guard;
   logic                     sticky;
   logic                     rnd_up;
   logic signed [EXPS_W-1:0] exp_n;
   logic signed [EXPS_W-1:0] exp_f;
   logic [FRAC_W-1:0]        frac_f;

   always_comb begin
      if (prod_i[PROD_W-1]) begin
         mant   = prod_i[47:24];
         guard  = prod_i[23];
         sticky = |prod_i[22:0];
         exp_n  = exp_i + 10'sd1;
      end else begin
         mant   = prod_i[46:23];
         guard  = prod_i[22];
         sticky = |prod_i[21:0];
         exp_n  = exp_i;
      end

      rnd_up = guard & (sticky | mant[0]);
      mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};

      // Rounding 1.111..1 up yields 10.000..0: fraction becomes zero, exponent bumps.
      if (mant_r[MANT_W]) begin
         frac_f = '0;
         exp_f  = exp_n + 10'sd1;
      end else begin
         frac_f = mant_r[FRAC_W-1:0];
         exp_f  = exp_n;
      end

      if (nan_i)
         res_o = QNAN;
      else if (inf_i)
         res_o = {sign_i, 8'hFF, {FRAC_W{1'b0}}};
      else if (zero_i)
         res_o = {sign_i, 31'd0};
      else if (exp_f >= 10'sd255)
         res_o = {sign_i, 8'hFF, {FRAC_W{1'b0}}};
      else if (exp_f <= 10'sd0)
         res_o = {sign_i, 31'd0};
      else
         res_o = {sign_i, exp_f[EXP_W-1:0], frac_f};
   end

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential shift-add IEEE-754 single-precision multiplier
// Purpose: accepts one operand pair in IDLE, builds the 48-bit mantissa product
//          BITS_PER_CYC bits per cycle, rounds/packs in one cycle, then holds
//          the result until consumed.
// Ports:   clk, rst_n (async active-low); in_valid/in_ready/InA/InB operand
//          handshake; out_valid/out_ready/Out result handshake.
module fp_mul_seq
   import fp_mul_seq_pkg::*;
#(
   parameter int BITS_PER_CYC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] InA,
   input  logic [31:0] InB,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] Out
);

   localparam int B     = BITS_PER_CYC;
   localparam int N_CYC = MANT_W / B;

   state_t                   state_q, state_d;
   logic [4:0]               cnt_q, cnt_d;
   logic [MANT_W-1:0]        ma_q, ma_d;
   logic [MANT_W-1:0]        mb_q, mb_d;
   logic [PROD_W-1:0]        acc_q, acc_d;
   logic                     sign_q, sign_d;
   logic signed [EXPS_W-1:0] exp_q, exp_d;
   logic [2:0]               flg_q, flg_d;   // {nan, inf, zero} of the product
   logic [31:0]              res_q, res_d;

   logic [2:0]               cls_a, cls_b;
   logic [MANT_W+B-1:0]      pp;
   logic [PROD_W+B-1:0]      sum_w;
   logic [31:0]              packed_res;

   assign cls_a = fp_class(InA);
   assign cls_b = fp_class(InB);

   // Partial product lands in the top half; shifting right each cycle means
   // digit i ends up weighted by 2^(i*B) after N_CYC steps with no bits lost.
   assign pp    = {{B{1'b0}}, ma_q} * {{MANT_W{1'b0}}, mb_q[B-1:0]};
   assign sum_w = {{B{1'b0}}, acc_q} + {pp, {MANT_W{1'b0}}};

   fp_round_pack u_round_pack (
      .sign_i (sign_q),
      .exp_i  (exp_q),
      .prod_i (acc_q),
      .nan_i  (flg_q[2]),
      .inf_i  (flg_q[1]),
      .zero_i (flg_q[0]),
      .res_o  (packed_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         flg_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         flg_q   <= flg_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      acc_d     = acc_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      flg_d     = flg_q;
      res_d     = res_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ma_d   = {InA[30:23] != '0, InA[22:0]};
               mb_d   = {InB[30:23] != '0, InB[22:0]};
               sign_d = InA[31] ^ InB[31];
               exp_d  = $signed({2'b00, InA[30:23]}) + $signed({2'b00, InB[30:23]})
                        - 10'(BIAS);
               // NaN operand or 0*inf wins over inf, which wins over zero.
               flg_d  = {cls_a[2] | cls_b[2] | (cls_a[1] & cls_b[0]) | (cls_b[1] & cls_a[0]),
                         cls_a[1] | cls_b[1],
                         cls_a[0] | cls_b[0]};
               acc_d  = '0;
               cnt_d  = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d = sum_w[PROD_W+B-1:B];
            mb_d  = mb_q >> B;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(N_CYC - 1))
               state_d = S_NORM;
         end
         S_NORM: begin
            res_d   = packed_res;
            state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign Out = res_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - self-checking scoreboard bench for fp_mul_seq
module tb_fp_mul_seq;

   localparam int BPC = 1;
   localparam int LAT = 24 / BPC + 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] InA;
   logic [31:0] InB;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Out;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   fp_mul_seq #(.BITS_PER_CYC(BPC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .InA       (InA),
      .InB       (InB),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Out       (Out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Called just after a negedge; pushes the expected result and drives one accept edge.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      chk("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
      InA      = a;
      InB      = b;
      in_valid = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (out_valid !== 1'b1)
         chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic pop_cmp(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk(tag, Out, e);
      end
   endtask

   task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
      int n;
      out_ready = 1'b1;
      issue(a, b, e);
      wait_out(n);
      chk({tag, "_latency"}, 32'(n), 32'(LAT));
      pop_cmp(tag);
      @(negedge clk);
      chk({tag, "_consumed_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_consumed_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   typedef struct {
      string       tag;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int          n;
      logic [31:0] held;

      vecs.push_back('{"two_x_three",   32'h4000_0000, 32'h4040_0000, 32'h40C0_0000});
      vecs.push_back('{"neg_two_x_three", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000});
      vecs.push_back('{"one5_sq",       32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000});
      vecs.push_back('{"inf_x_zero",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000});
      vecs.push_back('{"overflow",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000});
      vecs.push_back('{"underflow",     32'h0080_0000, 32'h0080_0000, 32'h0000_0000});
      vecs.push_back('{"nan_in",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000});
      vecs.push_back('{"inf_x_two",     32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000});
      vecs.push_back('{"negzero_x_3",   32'h8000_0000, 32'h4040_0000, 32'h8000_0000});
      vecs.push_back('{"denorm_x_2",    32'h0000_0001, 32'h4000_0000, 32'h0000_0000});
      vecs.push_back('{"no_round",      32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002});
      vecs.push_back('{"max_mant_sq",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE});
      vecs.push_back('{"round_carry",   32'h3F7F_FFFF, 32'h3F80_0001, 32'h3F80_0000});

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      InA       = '0;
      InB       = '0;
      repeat (2) @(negedge clk);
      chk("reset_out",       Out,                   32'd0);
      chk("reset_out_valid", {31'd0, out_valid},    32'd0);
      chk("reset_in_ready",  {31'd0, in_ready},     32'd1);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_one(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].e);

      // Back-pressure: result must hold and a second request must be ignored.
      out_ready = 1'b0;
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      wait_out(n);
      chk("hold_latency", 32'(n), 32'(LAT));
      held = Out;
      for (int i = 0; i < 10; i++) begin
         InA      = 32'h3F80_0000;
         InB      = 32'h4100_0000;
         in_valid = 1'b1;
         @(negedge clk);
         chk("hold_out",       Out,                held);
         chk("hold_in_ready",  {31'd0, in_ready},  32'd0);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid  = 1'b0;
      pop_cmp("hold_result");
      out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", {31'd0, out_valid},       32'd0);
      chk("hold_release_ready", {31'd0, in_ready},        32'd1);
      chk("hold_sb_drained",    32'(exp_q.size()),        32'd0);

      // Reset in the middle of the multiply phase.
      issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      repeat (12) @(negedge clk);
      chk("pre_reset_busy", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midreset_in_ready",  {31'd0, in_ready},  32'd1);
      chk("midreset_out",       Out,                32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      run_one("after_reset", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
